fifo_sync_param: RTL

- Parametrised single-clock FIFO. Next-generation storage block behind the FIFO write/read agents.
- Generalises the fixed 8-bit FIFO with:
  - configurable data width and depth
  - programmable almost-full and almost-empty thresholds
  - an occupancy count
  - overflow and underflow error pulses
  - synchronous flush
- Write side keeps the existing write_en / data_in / full handshake, so current write drivers and monitors connect unchanged.

---
 rtl/fifo_sync_param_if.sv | 31 +++
 rtl/fifo_sync_param.sv | 69 ++++++
 2 files changed

// File: rtl/fifo_sync_param_if.sv
// Handshake and status bundle for the parametrised synchronous FIFO.
// The master side is the write/read agent; the slave side is the FIFO itself.
interface fifo_sync_param_if #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
);
   localparam int ADDR_W = $clog2(DEPTH);

   logic              flush;
   logic              write_en;
   logic [DATA_W-1:0] data_in;
   logic              full;
   logic              read_en;
   logic [DATA_W-1:0] data_out;
   logic              empty;
   logic              almost_full;
   logic              almost_empty;
   logic [ADDR_W:0]   count;
   logic              overflow;
   logic              underflow;

   modport master (
      output flush, write_en, data_in, read_en,
      input  full, data_out, empty, almost_full, almost_empty, count, overflow, underflow
   );

   modport slave (
      input  flush, write_en, data_in, read_en,
      output full, data_out, empty, almost_full, almost_empty, count, overflow, underflow
   );
endinterface

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with wrap-bit pointers, programmable almost flags,
// occupancy count, overflow/underflow pulses and synchronous flush.
module fifo_sync_param #(
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = 12,
   parameter int AE_LEVEL = 4
) (
   input logic               clk,
   input logic               reset,
   fifo_sync_param_if.slave  bus
);
   localparam int ADDR_W = $clog2(DEPTH);
   localparam logic [ADDR_W:0] AF_TH = (ADDR_W+1)'(AF_LEVEL);
   localparam logic [ADDR_W:0] AE_TH = (ADDR_W+1)'(AE_LEVEL);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W:0]   wr_ptr, rd_ptr, count;
   logic [DATA_W-1:0] data_q;
   logic              ovf_q, unf_q;
   logic              empty, full, wr_acc, rd_acc;

   // Status decodes come straight off the registered pointers.
   assign count  = wr_ptr - rd_ptr;
   assign empty  = (wr_ptr == rd_ptr);
   assign full   = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                   (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);

   // A full FIFO still takes a write when a read frees a slot this cycle.
   assign rd_acc = bus.read_en && !empty;
   assign wr_acc = bus.write_en && (!full || rd_acc);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         data_q <= '0;
         ovf_q  <= 1'b0;
         unf_q  <= 1'b0;
      end else if (bus.flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         ovf_q  <= 1'b0;
         unf_q  <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
         if (rd_acc) begin
            rd_ptr <= rd_ptr + 1'b1;
            data_q <= mem[rd_ptr[ADDR_W-1:0]];
         end
         ovf_q <= bus.write_en && !wr_acc;
         unf_q <= bus.read_en && !rd_acc;
      end
   end

   // Storage is not reset; when full with read+write the read sees the old word.
   always_ff @(posedge clk) begin
      if (!bus.flush && wr_acc) mem[wr_ptr[ADDR_W-1:0]] <= bus.data_in;
   end

   assign bus.count        = count;
   assign bus.empty        = empty;
   assign bus.full         = full;
   assign bus.almost_full  = (count >= AF_TH);
   assign bus.almost_empty = (count <= AE_TH);
   assign bus.data_out     = data_q;
   assign bus.overflow     = ovf_q;
   assign bus.underflow    = unf_q;
endmodule
